delta_controller_input_loader: RTL and testbench

Upstream neighbour of the output-extraction stage. It streams one layer's input feature map from DRAM into the Input SRAM before compute starts. It issues sequential 32-bit DRAM reads, packs each pair of words into a 64-bit SRAM line (8 x BIN_LEN elements), and writes lines to consecutive Input SRAM addresses. It pulses `finished` when the whole (channel, row, column) volume is resident.

---
 rtl/delta_pkg.sv | 26 ++
 rtl/delta_word_packer.sv | 36 +++
 rtl/delta_controller_input_loader.sv | 129 ++++++++++++
 tb/tb_delta_controller_input_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delta_pkg.sv
// delta_pkg
//   Shared definitions for the delta controller loaders: the loader state
//   encoding, SRAM line geometry, DRAM word size and the round-up helper
//   that pads a feature-map edge to a whole number of SRAM lines.
package delta_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      RD_LO,
      RD_HI,
      SRAM_WR,
      FINISH
   } state_t;

   localparam int SRAM_LINE_BITS  = 64;
   localparam int ELEMS_PER_LINE  = 8;
   localparam int DRAM_WORD_BYTES = 4;

   // Rounds a row/column count up to the next multiple of 8 elements so that
   // each padded row fills whole SRAM lines.
   function automatic logic [31:0] round_up8(input logic [31:0] size);
      return (size + 32'd7) & ~32'd7;
   endfunction

endpackage

// File: rtl/delta_word_packer.sv
// delta_word_packer
//   Assembles a 64-bit SRAM line from two consecutive 32-bit DRAM words.
//   The low strobe captures into line[31:0], the high strobe into line[63:32];
//   untouched halves keep their previous contents.
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-high reset, clears the line
//   capture_lo  load word into the low half this cycle
//   capture_hi  load word into the high half this cycle
//   word        32-bit word from DRAM
//   line        registered 64-bit packed line {high word, low word}
module delta_word_packer
   import delta_pkg::*;
(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      capture_lo,
   input  logic                      capture_hi,
   input  logic [31:0]               word,
   output logic [SRAM_LINE_BITS-1:0] line
);

   always_ff @(posedge clock) begin
      if (reset) begin
         line <= '0;
      end else begin
         if (capture_lo) begin
            line[31:0] <= word;
         end
         if (capture_hi) begin
            line[SRAM_LINE_BITS-1:32] <= word;
         end
      end
   end

endmodule

// File: rtl/delta_controller_input_loader.sv
// delta_controller_input_loader
//   Streams one layer's input feature map from DRAM into the Input SRAM.
//   Each SRAM line is built from two sequential 32-bit DRAM reads and written
//   to consecutive element addresses (8 elements per line). A one-cycle
//   finished pulse marks the end of the load.
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   start_DRAM_load      begins a load when seen in IDLE
//   IC_Num, IRC_Size     input channel count and row/column size
//   input_start_address  DRAM byte address of the first word
//   DRAM_*               read request/address, read data and completion
//   Input_SRAM_*         packed line, element address, write request/done
//   finished             one-cycle end-of-load pulse
module delta_controller_input_loader
   import delta_pkg::*;
#(
   parameter int BIN_LEN           = 8,
   parameter int MAX_INPUT_CHANNEL = 256,
   parameter int MAX_FEATURE_SIZE  = 256
)
(
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                start_DRAM_load,
   input  logic [$clog2(MAX_INPUT_CHANNEL):0]  IC_Num,
   input  logic [$clog2(MAX_FEATURE_SIZE):0]   IRC_Size,
   input  logic [31:0]                         input_start_address,
   output logic                                DRAM_Read,
   output logic [31:0]                         DRAM_Address,
   input  logic [31:0]                         DRAM_ReadData,
   input  logic                                DRAM_ReadDone,
   output logic [63:0]                         Input_SRAM_w_d,
   output logic [31:0]                         Input_SRAM_w_addr,
   output logic                                Input_SRAM_w_en,
   input  logic                                Input_SRAM_w_done,
   output logic                                finished
);

   localparam int LINE_STRIDE = SRAM_LINE_BITS / BIN_LEN;

   state_t      state;
   logic [31:0] dram_address;
   logic [31:0] sram_addr;
   logic [31:0] line_count;
   logic [31:0] total_lines;
   logic [31:0] rc_padded;
   logic [31:0] volume_lines;
   logic        capture_lo;
   logic        capture_hi;

   // Line count of the requested volume: every padded row holds rc/8 lines,
   // and there are rc rows per channel. Kept in 32 bits so large maps wrap
   // rather than truncate mid-product.
   assign rc_padded    = round_up8(32'(IRC_Size));
   assign volume_lines = 32'(IC_Num) * rc_padded * (rc_padded / 32'(ELEMS_PER_LINE));

   // Read completions only matter in the two read states; strays elsewhere
   // must not disturb the line being assembled.
   assign capture_lo = (state == RD_LO) && DRAM_ReadDone;
   assign capture_hi = (state == RD_HI) && DRAM_ReadDone;

   // Loader FSM with its address and line counters. Inputs are sampled only
   // at start; the counters keep their final values after FINISH.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         dram_address <= input_start_address;
         sram_addr    <= '0;
         line_count   <= '0;
         total_lines  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_DRAM_load) begin
                  total_lines  <= volume_lines;
                  dram_address <= input_start_address;
                  sram_addr    <= '0;
                  line_count   <= '0;
                  state        <= CHECK;
               end
            end
            CHECK: begin
               state <= (line_count == total_lines) ? FINISH : RD_LO;
            end
            RD_LO: begin
               if (DRAM_ReadDone) begin
                  dram_address <= dram_address + 32'(DRAM_WORD_BYTES);
                  state        <= RD_HI;
               end
            end
            RD_HI: begin
               if (DRAM_ReadDone) begin
                  dram_address <= dram_address + 32'(DRAM_WORD_BYTES);
                  state        <= SRAM_WR;
               end
            end
            SRAM_WR: begin
               if (Input_SRAM_w_done) begin
                  line_count <= line_count + 32'd1;
                  sram_addr  <= sram_addr + 32'(LINE_STRIDE);
                  state      <= CHECK;
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   delta_word_packer u_packer (
      .clock      (clock),
      .reset      (reset),
      .capture_lo (capture_lo),
      .capture_hi (capture_hi),
      .word       (DRAM_ReadData),
      .line       (Input_SRAM_w_d)
   );

   assign DRAM_Read         = (state == RD_LO) || (state == RD_HI);
   assign Input_SRAM_w_en   = (state == SRAM_WR);
   assign finished          = (state == FINISH);
   assign DRAM_Address      = dram_address;
   assign Input_SRAM_w_addr = sram_addr;

endmodule

// File: tb/tb_delta_controller_input_loader.sv
// tb_delta_controller_input_loader
//   Directed bench for the input loader. A responder process plays DRAM and
//   SRAM with configurable completion delays; expected reads and writes are
//   queued when each load is started and popped as the DUT issues them.
module tb_delta_controller_input_loader;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_DRAM_load;
   logic [8:0]  IC_Num;
   logic [8:0]  IRC_Size;
   logic [31:0] input_start_address;
   logic        DRAM_Read;
   logic [31:0] DRAM_Address;
   logic [31:0] DRAM_ReadData;
   logic        DRAM_ReadDone;
   logic [63:0] Input_SRAM_w_d;
   logic [31:0] Input_SRAM_w_addr;
   logic        Input_SRAM_w_en;
   logic        Input_SRAM_w_done;
   logic        finished;

   typedef struct packed {
      logic [31:0] addr;
      logic [63:0] data;
   } wr_t;

   int          tests_run  = 0;
   int          fail_count = 0;
   logic [31:0] rd_q[$];
   wr_t         wr_q[$];
   int          read_delay  = 0;
   int          write_delay = 0;
   bit          stray_on    = 1'b0;
   int          read_cycles  = 0;
   int          write_cycles = 0;

   localparam int LIMIT = 20000;

   always #5 clock = ~clock;

   delta_controller_input_loader dut (
      .clock               (clock),
      .reset               (reset),
      .start_DRAM_load     (start_DRAM_load),
      .IC_Num              (IC_Num),
      .IRC_Size            (IRC_Size),
      .input_start_address (input_start_address),
      .DRAM_Read           (DRAM_Read),
      .DRAM_Address        (DRAM_Address),
      .DRAM_ReadData       (DRAM_ReadData),
      .DRAM_ReadDone       (DRAM_ReadDone),
      .Input_SRAM_w_d      (Input_SRAM_w_d),
      .Input_SRAM_w_addr   (Input_SRAM_w_addr),
      .Input_SRAM_w_en     (Input_SRAM_w_en),
      .Input_SRAM_w_done   (Input_SRAM_w_done),
      .finished            (finished)
   );

   // DRAM contents: distinct per address so swapped or repeated words show.
   function automatic logic [31:0] dram_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'hC3A5_0F1E;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_nonempty(input string tag, input int size);
      tests_run++;
      assert (size != 0) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed no pending expectation, expected one", tag);
      end
   endtask

   // Memory responder: completes a request after its delay, checks that the
   // request is stable while waiting, and optionally fires stray completions
   // whenever nothing is requested.
   initial begin : responder
      int          rd_cnt = 0;
      int          wr_cnt = 0;
      logic [31:0] held_addr  = '0;
      logic [31:0] held_waddr = '0;
      logic [63:0] held_wd    = '0;
      logic [31:0] exp_addr;
      wr_t         exp_wr;
      DRAM_ReadDone     = 1'b0;
      DRAM_ReadData     = '0;
      Input_SRAM_w_done = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            DRAM_ReadDone     = 1'b0;
            Input_SRAM_w_done = 1'b0;
            rd_cnt = 0;
            wr_cnt = 0;
         end else begin
            if (DRAM_Read) begin
               read_cycles++;
               if (rd_cnt > 0) check("dram_addr_stable", DRAM_Address, held_addr);
               else held_addr = DRAM_Address;
               if (rd_cnt >= read_delay) begin
                  check_nonempty("read_expected", rd_q.size());
                  if (rd_q.size() != 0) begin
                     exp_addr = rd_q.pop_front();
                     check("dram_addr", DRAM_Address, exp_addr);
                  end
                  DRAM_ReadData = dram_word(DRAM_Address);
                  DRAM_ReadDone = 1'b1;
                  rd_cnt = 0;
               end else begin
                  DRAM_ReadDone = 1'b0;
                  DRAM_ReadData = 32'hDEAD_BEEF;
                  rd_cnt++;
               end
            end else begin
               rd_cnt = 0;
               DRAM_ReadDone = stray_on;
               DRAM_ReadData = 32'hDEAD_BEEF;
            end
            if (Input_SRAM_w_en) begin
               write_cycles++;
               if (wr_cnt > 0) begin
                  check("w_addr_stable", Input_SRAM_w_addr, held_waddr);
                  check("w_d_stable", Input_SRAM_w_d, held_wd);
               end else begin
                  held_waddr = Input_SRAM_w_addr;
                  held_wd    = Input_SRAM_w_d;
               end
               if (wr_cnt >= write_delay) begin
                  check_nonempty("write_expected", wr_q.size());
                  if (wr_q.size() != 0) begin
                     exp_wr = wr_q.pop_front();
                     check("w_addr", Input_SRAM_w_addr, exp_wr.addr);
                     check("w_d", Input_SRAM_w_d, exp_wr.data);
                  end
                  Input_SRAM_w_done = 1'b1;
                  wr_cnt = 0;
               end else begin
                  Input_SRAM_w_done = 1'b0;
                  wr_cnt++;
               end
            end else begin
               wr_cnt = 0;
               Input_SRAM_w_done = stray_on;
            end
         end
      end
   end

   // Queues every read and write the load should produce and returns the
   // line count of the padded volume.
   task automatic push_expected(input int ic, input int irc, input logic [31:0] base,
                                output int lines);
      int  rc;
      wr_t w;
      rc    = ((irc + 7) / 8) * 8;
      lines = ic * rc * (rc / 8);
      for (int n = 0; n < lines; n++) begin
         rd_q.push_back(base + 32'(8 * n));
         rd_q.push_back(base + 32'(8 * n + 4));
         w.addr = 32'(8 * n);
         w.data = {dram_word(base + 32'(8 * n + 4)), dram_word(base + 32'(8 * n))};
         wr_q.push_back(w);
      end
   endtask

   task automatic applyStimulus(input int ic, input int irc, input logic [31:0] base,
                                output int lines);
      push_expected(ic, irc, base, lines);
      IC_Num              = 9'(ic);
      IRC_Size            = 9'(irc);
      input_start_address = base;
      start_DRAM_load     = 1'b1;
      @(negedge clock);
      start_DRAM_load     = 1'b0;
   endtask

   // Called at the first negedge after the start edge; exp_edges < 0 skips
   // the latency comparison.
   task automatic checkOutput(input string tag, input int exp_edges);
      int n = 1;
      while (finished !== 1'b1 && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_finished_seen"}, finished, 1'b1);
      if (exp_edges >= 0) check({tag, "_latency"}, n, exp_edges);
      @(negedge clock);
      check({tag, "_pulse_one_cycle"}, finished, 1'b0);
      check({tag, "_reads_left"}, rd_q.size(), 0);
      check({tag, "_writes_left"}, wr_q.size(), 0);
   endtask

   initial begin : main
      int lines;
      int lines2;
      int n;
      int rc0;
      int wc0;
      reset               = 1'b1;
      start_DRAM_load     = 1'b0;
      IC_Num              = '0;
      IRC_Size            = '0;
      input_start_address = 32'h0000_1000;
      repeat (2) @(negedge clock);
      check("reset_dram_read", DRAM_Read, 1'b0);
      check("reset_w_en", Input_SRAM_w_en, 1'b0);
      check("reset_finished", finished, 1'b0);
      check("reset_w_d", Input_SRAM_w_d, 64'h0);
      check("reset_w_addr", Input_SRAM_w_addr, 32'h0);
      check("reset_dram_addr", DRAM_Address, 32'h0000_1000);
      reset = 1'b0;
      @(negedge clock);

      $display("[TB] basic load IC=1 IRC=8");
      applyStimulus(1, 8, 32'h0000_1000, lines);
      checkOutput("basic", 2 + 4 * lines);

      $display("[TB] padded load IC=2 IRC=5");
      applyStimulus(2, 5, 32'h0000_1000, lines);
      checkOutput("padded", 2 + 4 * lines);
      check("padded_final_dram_addr", DRAM_Address, 32'h0000_1080);
      check("padded_final_w_addr", Input_SRAM_w_addr, 32'd128);

      $display("[TB] rounding load IC=1 IRC=9");
      applyStimulus(1, 9, 32'h0000_6000, lines);
      checkOutput("round9", 2 + 4 * lines);

      $display("[TB] zero-volume loads");
      rc0 = read_cycles;
      wc0 = write_cycles;
      applyStimulus(0, 8, 32'h0000_7000, lines);
      checkOutput("zero_ic", 2);
      applyStimulus(4, 0, 32'h0000_7000, lines);
      checkOutput("zero_rc", 2);
      check("zero_no_read", read_cycles - rc0, 0);
      check("zero_no_write", write_cycles - wc0, 0);

      $display("[TB] delayed completions with stray pulses");
      read_delay  = 3;
      write_delay = 2;
      stray_on    = 1'b1;
      applyStimulus(1, 3, 32'h0000_5000, lines);
      checkOutput("delayed", 2 + lines * (1 + 2 * (3 + 1) + (2 + 1)));
      read_delay  = 0;
      write_delay = 0;
      stray_on    = 1'b0;
      @(negedge clock);

      $display("[TB] reset in RD_HI of line 3");
      push_expected(1, 8, 32'h0000_2000, lines);
      IC_Num              = 9'd1;
      IRC_Size            = 9'd8;
      input_start_address = 32'h0000_2000;
      start_DRAM_load     = 1'b1;
      @(negedge clock);
      start_DRAM_load     = 1'b0;
      n = 0;
      while (!(DRAM_Read === 1'b1 && DRAM_Address === 32'h0000_201C) && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      check("midreset_reached_rd_hi", DRAM_Address, 32'h0000_201C);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      rd_q.delete();
      wr_q.delete();
      check("midreset_dram_read", DRAM_Read, 1'b0);
      check("midreset_w_en", Input_SRAM_w_en, 1'b0);
      check("midreset_finished", finished, 1'b0);
      check("midreset_w_d", Input_SRAM_w_d, 64'h0);
      check("midreset_w_addr", Input_SRAM_w_addr, 32'h0);
      check("midreset_dram_addr", DRAM_Address, 32'h0000_2000);
      rc0 = read_cycles;
      wc0 = write_cycles;
      repeat (5) @(negedge clock);
      check("midreset_abandoned_reads", read_cycles - rc0, 0);
      check("midreset_abandoned_writes", write_cycles - wc0, 0);
      applyStimulus(1, 8, 32'h0000_2000, lines);
      checkOutput("after_reset", 2 + 4 * lines);

      $display("[TB] start held high with changing IC_Num");
      push_expected(1, 8, 32'h0000_4000, lines);
      IC_Num              = 9'd1;
      IRC_Size            = 9'd8;
      input_start_address = 32'h0000_4000;
      start_DRAM_load     = 1'b1;
      @(negedge clock);
      n = 1;
      while (finished !== 1'b1 && n < LIMIT) begin
         IC_Num              = IC_Num + 9'd1;
         input_start_address = input_start_address + 32'h100;
         @(negedge clock);
         n++;
      end
      check("held_latency", n, 2 + 4 * lines);
      push_expected(2, 5, 32'h0000_1000, lines2);
      IC_Num              = 9'd2;
      IRC_Size            = 9'd5;
      input_start_address = 32'h0000_1000;
      @(negedge clock);
      check("held_idle_finished_low", finished, 1'b0);
      check("held_idle_no_read", DRAM_Read, 1'b0);
      @(negedge clock);
      start_DRAM_load = 1'b0;
      checkOutput("held_second", 2 + 4 * lines2);
      check("held_final_dram_addr", DRAM_Address, 32'h0000_1080);
      check("held_final_w_addr", Input_SRAM_w_addr, 32'd128);

      repeat (3) @(negedge clock);
      check("idle_no_restart", DRAM_Read, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
